// File: rtl/strobe_pkg.sv
// Shared definitions for the strobe edge detector: per-channel edge-mode
// encodings, parameter defaults and the edge qualification helper.
package strobe_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    localparam int DEF_CHANNELS    = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_CYCLES = 4;
    localparam int DEF_RESET_LEVEL = 0;

    function automatic logic edge_qualifies(edge_mode_e m, logic rise, logic fall);
        return (rise && (m == MODE_RISE || m == MODE_BOTH)) ||
               (fall && (m == MODE_FALL || m == MODE_BOTH));
    endfunction

endpackage

// File: rtl/strobe_edge_chan.sv
// One channel of strobe_edge_detect: synchroniser, optional glitch filter
// (compiled in by STROBE_FILTER_EN), edge detector and sticky pending flag.
module strobe_edge_chan
    import strobe_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
`ifdef STROBE_FILTER_EN
    parameter int FILT_CYCLES = DEF_FILT_CYCLES,
`endif
    parameter int RESET_LEVEL = DEF_RESET_LEVEL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       strobe,
    output logic       level,
    output logic       pend
);

    localparam logic RST_LVL = (RESET_LEVEL != 0);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   f;
    logic                   f_d;
    logic                   rise;
    logic                   fall;
    logic                   strobe_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {SYNC_STAGES{RST_LVL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync[SYNC_STAGES-1];

`ifdef STROBE_FILTER_EN
    localparam int            CW       = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // The level only moves once s has disagreed with it for FILT_CYCLES edges in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            f   <= RST_LVL;
        end else if (s == f) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            f   <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    // Without the filter the last synchroniser stage already is the level register.
    assign f = s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_d <= RST_LVL;
        end else begin
            f_d <= f;
        end
    end

    assign rise       = f & ~f_d;
    assign fall       = ~f & f_d;
    assign strobe_nxt = edge_qualifies(edge_mode_e'(mode), rise, fall);

    // A new event outranks a clear arriving on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe <= 1'b0;
            pend   <= 1'b0;
        end else begin
            strobe <= strobe_nxt;
            pend   <= strobe_nxt | (pend & ~clr);
        end
    end

    assign level = f;

endmodule

// File: rtl/strobe_edge_detect.sv
// Multi-channel strobe edge detector; one strobe_edge_chan per input channel.
// Define STROBE_FILTER_EN to build in the per-channel glitch filter.
module strobe_edge_detect
    import strobe_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int RESET_LEVEL = DEF_RESET_LEVEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   strobe,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pend
);

    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
        $error("strobe_edge_detect: CHANNELS must be in 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("strobe_edge_detect: SYNC_STAGES must be at least 2");
    end
    if (FILT_CYCLES < 1) begin : g_bad_filt
        $error("strobe_edge_detect: FILT_CYCLES must be at least 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        strobe_edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
`ifdef STROBE_FILTER_EN
            .FILT_CYCLES (FILT_CYCLES),
`endif
            .RESET_LEVEL (RESET_LEVEL)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .din    (in[i]),
            .mode   (mode[2*i +: 2]),
            .clr    (clr[i]),
            .strobe (strobe[i]),
            .level  (level[i]),
            .pend   (pend[i])
        );
    end

endmodule

// File: tb/tb_strobe_edge_detect.sv
// Self-checking bench for strobe_edge_detect: vector table, corner-case
// sequences and a randomized run against a behavioural reference model.
module tb_strobe_edge_detect;

    localparam int CH   = 8;
    localparam int SYNC = 2;
    localparam int FILT = 4;
`ifdef STROBE_FILTER_EN
    localparam int LAT  = SYNC + FILT + 1;
`else
    localparam int LAT  = SYNC + 1;
`endif
    localparam logic [CH-1:0] RLV = '0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   in_v = '0;
    logic [2*CH-1:0] mode_v = '0;
    logic [CH-1:0]   clr_v = '0;
    logic [CH-1:0]   strobe, level, pend;
    logic [CH-1:0]   strobe1, level1, pend1;

    int n_cmp = 0;
    int n_fail = 0;

    strobe_edge_detect #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .RESET_LEVEL(0)
    ) dut (
        .clk(clk), .rst(rst), .in(in_v), .mode(mode_v), .clr(clr_v),
        .strobe(strobe), .level(level), .pend(pend)
    );

    strobe_edge_detect #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .RESET_LEVEL(1)
    ) dut1 (
        .clk(clk), .rst(rst), .in(in_v), .mode(mode_v), .clr(clr_v),
        .strobe(strobe1), .level(level1), .pend(pend1)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: a fixed delay line for synchronisation, a run-length
    // rule for the filter, and edges seen as changes between successive levels.
    logic [CH-1:0] m_q[$];
    logic [CH-1:0] m_lvl1, m_lvl2, m_strobe, m_pend;
    logic [CH-1:0] ms_new, ml_new, mstb_new;
    logic [1:0]    mm;
    logic          want_rise, want_fall;
`ifdef STROBE_FILTER_EN
    logic [CH-1:0] m_s;
    int            m_run[CH];
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            for (int k = 0; k < SYNC - 1; k++) m_q.push_back(RLV);
            m_lvl1   = RLV;
            m_lvl2   = RLV;
            m_strobe = '0;
            m_pend   = '0;
`ifdef STROBE_FILTER_EN
            m_s = RLV;
            for (int c = 0; c < CH; c++) m_run[c] = 0;
`endif
        end else begin
            for (int c = 0; c < CH; c++) begin
                mm        = mode_v[2*c +: 2];
                want_rise = (mm == 2'b01) || (mm == 2'b11);
                want_fall = (mm == 2'b10) || (mm == 2'b11);
                mstb_new[c] = (m_lvl1[c] != m_lvl2[c]) && (m_lvl1[c] ? want_rise : want_fall);
            end
            m_q.push_back(in_v);
            ms_new = m_q.pop_front();
`ifdef STROBE_FILTER_EN
            for (int c = 0; c < CH; c++) begin
                if (m_s[c] != m_lvl1[c]) m_run[c]++;
                else                     m_run[c] = 0;
                if (m_run[c] >= FILT) begin
                    ml_new[c] = m_s[c];
                    m_run[c]  = 0;
                end else begin
                    ml_new[c] = m_lvl1[c];
                end
            end
            m_s = ms_new;
`else
            ml_new = ms_new;
`endif
            m_pend   = mstb_new | (m_pend & ~clr_v);
            m_strobe = mstb_new;
            m_lvl2   = m_lvl1;
            m_lvl1   = ml_new;
        end
    end

    task automatic checkOutput(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [CH-1:0] i, input logic [2*CH-1:0] m, input logic [CH-1:0] c);
        in_v   = i;
        mode_v = m;
        clr_v  = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int         ch;
        logic [1:0] m;
        logic       val;
        logic       exp;
    } vec_t;

    vec_t            tbl[10];
    logic [CH-1:0]   nin, emask;
    logic [2*CH-1:0] mall;

    initial begin
        tbl[0] = '{0, 2'b01, 1'b1, 1'b1};
        tbl[1] = '{0, 2'b01, 1'b0, 1'b0};
        tbl[2] = '{1, 2'b10, 1'b1, 1'b0};
        tbl[3] = '{1, 2'b10, 1'b0, 1'b1};
        tbl[4] = '{3, 2'b11, 1'b1, 1'b1};
        tbl[5] = '{3, 2'b11, 1'b0, 1'b1};
        tbl[6] = '{4, 2'b00, 1'b1, 1'b0};
        tbl[7] = '{4, 2'b00, 1'b0, 1'b0};
        tbl[8] = '{7, 2'b11, 1'b1, 1'b1};
        tbl[9] = '{6, 2'b01, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        checkOutput("reset_strobe", strobe, '0);
        checkOutput("reset_level", level, '0);
        checkOutput("reset_pend", pend, '0);
        checkOutput("reset_level_rl1", level1, {CH{1'b1}});
        rst = 1'b0;
        @(negedge clk);

        // Single-channel edges under each mode.
        for (int r = 0; r < 10; r++) begin
            nin = in_v;
            nin[tbl[r].ch] = tbl[r].val;
            mall  = {CH{tbl[r].m}};
            emask = tbl[r].exp ? (CH'(1) << tbl[r].ch) : '0;
            applyStimulus(nin, mall, '1);
            for (int k = 2; k <= LAT + 1; k++) begin
                applyStimulus(nin, mall, '0);
                if (k == LAT - 1) checkOutput($sformatf("tbl%0d_early", r), strobe, '0);
                if (k == LAT) begin
                    checkOutput($sformatf("tbl%0d_strobe", r), strobe, emask);
                    checkOutput($sformatf("tbl%0d_pend", r), pend, emask);
                end
                if (k == LAT + 1) begin
                    checkOutput($sformatf("tbl%0d_after", r), strobe, '0);
                    checkOutput($sformatf("tbl%0d_level", r), CH'(level[tbl[r].ch]), CH'(tbl[r].val));
                end
            end
        end

        // Both-edge mode: rise and fall strobes exactly 10 cycles apart.
        begin
            int cnt3, first3, last3;
            cnt3 = 0; first3 = -1; last3 = -1;
            mall = '0;
            mall[7:6] = 2'b11;
            for (int k = 1; k <= 10 + LAT + 4; k++) begin
                nin = in_v;
                nin[3] = (k <= 10);
                applyStimulus(nin, mall, '0);
                if (strobe[3]) begin
                    cnt3++;
                    if (first3 < 0) first3 = k;
                    last3 = k;
                end
            end
            checkOutput("both_count", CH'(cnt3), CH'(2));
            checkOutput("both_gap", CH'(last3 - first3), CH'(10));
            checkOutput("both_first", CH'(first3), CH'(LAT));
        end

        // Clear coinciding with a new strobe keeps pend; a later clear drops it.
        mall = '0;
        mall[5:4] = 2'b11;
        nin = in_v;
        nin[2] = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) applyStimulus(nin, mall, '0);
        checkOutput("pend2_set", CH'(pend[2]), CH'(1));
        nin[2] = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            applyStimulus(nin, mall, (k == LAT || k == LAT + 1) ? CH'(4) : '0);
            if (k == LAT) begin
                checkOutput("clr_vs_strobe_strobe", CH'(strobe[2]), CH'(1));
                checkOutput("clr_vs_strobe_pend", CH'(pend[2]), CH'(1));
            end
            if (k == LAT + 1) checkOutput("clr_alone_pend", CH'(pend[2]), CH'(0));
            if (k == LAT + 2) checkOutput("clr_hold_pend", CH'(pend[2]), CH'(0));
        end

        // Inputs held high through reset: one strobe per channel for level 0, none for level 1.
        mall = {CH{2'b01}};
        in_v = {CH{1'b1}};
        mode_v = mall;
        clr_v = '0;
        doReset();
        for (int k = 1; k <= LAT + 2; k++) begin
            applyStimulus({CH{1'b1}}, mall, '0);
            checkOutput($sformatf("rst_ff_strobe_e%0d", k), strobe, (k == LAT) ? {CH{1'b1}} : '0);
            checkOutput($sformatf("rst_ff_strobe_rl1_e%0d", k), strobe1, '0);
        end
        checkOutput("rst_ff_level_rl1", level1, {CH{1'b1}});
        checkOutput("rst_ff_pend_rl1", pend1, '0);
        checkOutput("rst_ff_pend", pend, {CH{1'b1}});

        // Reset in the middle of a pending edge on channel 5.
        in_v = '0;
        doReset();
        for (int k = 1; k <= SYNC + 2; k++) applyStimulus(CH'(8'h20), mall, '0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_strobe", strobe, '0);
        checkOutput("midrst_pend", pend, '0);
        checkOutput("midrst_level", level, '0);
        in_v = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus('0, mall, '0);
            checkOutput($sformatf("midrst_post_e%0d", k), strobe, '0);
        end
        checkOutput("midrst_post_pend", pend, '0);

`ifdef STROBE_FILTER_EN
        // Short pulses are swallowed by the filter; longer ones pass with filter latency.
        mall = {CH{2'b11}};
        for (int k = 1; k <= 15; k++) begin
            applyStimulus((k <= 3) ? CH'(2) : '0, mall, '0);
            checkOutput($sformatf("filt_short_strobe_e%0d", k), strobe, '0);
            checkOutput($sformatf("filt_short_level_e%0d", k), level, '0);
        end
        for (int k = 1; k <= 20; k++) begin
            applyStimulus((k <= 6) ? CH'(2) : '0, mall, '0);
            checkOutput($sformatf("filt_long_e%0d", k), strobe,
                        (k == LAT || k == LAT + 6) ? CH'(2) : '0);
        end
`endif

        // Randomized traffic against the reference model.
        in_v = '0;
        doReset();
        nin  = '0;
        mall = 16'($urandom);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) doReset();
            if ($urandom_range(0, 31) == 0) mall = 16'($urandom);
            nin = nin ^ CH'($urandom & $urandom & $urandom);
            applyStimulus(nin, mall, ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0);
            checkOutput("rand_strobe", strobe, m_strobe);
            checkOutput("rand_level", level, m_lvl1);
            checkOutput("rand_pend", pend, m_pend);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/strobe_edge_detect.md
STROBE_EDGE_DETECT -- requirements
Module: strobe_edge_detect

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 8, giving the number of independent input channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth per channel (minimum 2).
REQ-003 The block SHALL have parameter FILT_CYCLES, default 4, giving the consecutive-cycle count for glitch-filter acceptance (minimum 1).
REQ-004 The block SHALL have parameter RESET_LEVEL, default 0, giving the level loaded into all synchroniser and level registers at reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port in, input, CHANNELS bits: asynchronous raw inputs, one per channel.
REQ-008 The block SHALL have port mode, input, 2*CHANNELS bits: per-channel edge select, bits [2i+1:2i]; 00 off, 01 rising, 10 falling, 11 both.
REQ-009 The block SHALL have port clr, input, CHANNELS bits: per-channel synchronous clear of the pending flag.
REQ-010 The block SHALL have port strobe, output, CHANNELS bits: registered one-cycle pulse per detected edge.
REQ-011 The block SHALL have port level, output, CHANNELS bits: synchronised (and filtered, if enabled) channel level.
REQ-012 The block SHALL have port pend, output, CHANNELS bits: sticky per-channel event flag.

Function
REQ-013 Each channel SHALL pass in[i] through a SYNC_STAGES-deep flop chain; the last stage is the synchronised value s.
REQ-014 The level register f SHALL follow s per REQ-027/028; level[i] SHALL equal f.
REQ-015 A delayed copy f_d SHALL be registered every cycle; rise = f & ~f_d, fall = ~f & f_d.
REQ-016 strobe[i] SHALL be registered from rise/fall gated by mode[i]; high for exactly one cycle per qualifying edge.
REQ-017 With filtering absent, a clean input step meeting setup before edge 1 SHALL assert strobe after edge SYNC_STAGES+1 and deassert after edge SYNC_STAGES+2.
REQ-018 mode 00 SHALL suppress strobe and pend set while level continues to track the input.
REQ-019 A mode change SHALL take effect at the next clock edge and SHALL NOT by itself generate a strobe.
REQ-020 pend[i] SHALL set on the cycle strobe[i] is asserted and hold until clr[i] is sampled high.
REQ-021 Simultaneous strobe and clr on a channel SHALL leave pend set (set wins).
REQ-022 Channels SHALL be fully independent; simultaneous events on all channels SHALL each produce their own strobe.

Reset
REQ-023 rst high SHALL immediately force all synchroniser stages, f and f_d to RESET_LEVEL, and filter counters, strobe and pend to 0.
REQ-024 After rst release with in[i] equal to RESET_LEVEL, no strobe SHALL occur; with in[i] opposite, one edge SHALL be reported with normal latency.
REQ-025 Reset asserted mid-filter or mid-pulse SHALL abort it with no residual strobe after release.

Configuration
REQ-026 Macro STROBE_FILTER_EN SHALL compile the glitch filter in; without it f SHALL load s every cycle and FILT_CYCLES SHALL be ignored.
REQ-027 With STROBE_FILTER_EN, a per-channel counter of width $clog2(FILT_CYCLES+1) SHALL increment each cycle s != f and clear when s == f.
REQ-028 With STROBE_FILTER_EN, f SHALL load s and the counter SHALL clear on the edge where s != f and the counter equals FILT_CYCLES-1; strobe latency becomes SYNC_STAGES+FILT_CYCLES+1 edges.
REQ-029 With STROBE_FILTER_EN, pulses on s shorter than FILT_CYCLES cycles SHALL produce no level change and no strobe.

Structure
REQ-030 Package strobe_pkg SHALL hold the mode encodings (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and the parameter defaults.
REQ-031 One sub-module strobe_edge_chan SHALL implement a single channel (sync, filter, detect, pend); the top SHALL generate CHANNELS instances.

Verification
REQ-032 No filter, CHANNELS=8, mode=all 01, in[0] 0->1 -> strobe[0] high one cycle after edge 3, pend[0]=1, other bits 0.
REQ-033 mode[3]=11, in[3] 0->1, hold 10 cycles, then 1->0 -> two one-cycle strobes on ch3, 10 cycles apart.
REQ-034 STROBE_FILTER_EN, FILT_CYCLES=4: 3-cycle high pulse on in[1] -> no strobe, level[1]=0; 6-cycle pulse -> one rise strobe after edge 7 and one fall strobe.
REQ-035 pend[2]=1, assert clr[2] in the same cycle as a new strobe[2] -> pend[2] stays 1; clr[2] alone next cycle -> pend[2]=0.
REQ-036 RESET_LEVEL=0, in=0xFF held through reset -> after release, strobe=0xFF once with mode all 01; RESET_LEVEL=1 -> no strobes.
REQ-037 rst asserted two cycles into a filter count on in[5] -> strobe, pend, level all 0 immediately; no strobe within 10 cycles after release with in[5]=0.
